// File: rtl/sha_input_manager.sv
// Work dispatcher: latches one work unit, broadcasts it to NUM_CORES cores and steps nonce batches
// until a find, nonce-space exhaustion or flush. Define SHA_IN_STATS_EN to add the hash_count output.
module sha_input_manager #(
    parameter int unsigned NUM_CORES   = 1,
    parameter logic [31:0] NONCE_START = 32'd0
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      work_valid,
    output logic                      work_ready,
    input  logic [351:0]              work_data,
    input  logic                      flush,
    output logic [351:0]              core_work,
    output logic [32*NUM_CORES-1:0]   core_nonce,
    output logic                      core_start,
    input  logic [NUM_CORES-1:0]      core_done,
    input  logic [NUM_CORES-1:0]      core_found,
    output logic                      busy,
    output logic                      found,
    output logic                      exhausted
`ifdef SHA_IN_STATS_EN
    ,
    output logic [47:0]               hash_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t                   state_q;
    logic [31:0]              base_q;
    logic [351:0]             core_work_q;
    logic [32*NUM_CORES-1:0]  core_nonce_q;
    logic                     work_ready_q;
    logic                     core_start_q;
    logic                     busy_q;
    logic                     found_q;
    logic                     exhausted_q;

    logic                     batch_complete;
    logic [32:0]              base_sum;
    logic [31:0]              next_base_d;
    logic [32*NUM_CORES-1:0]  core_nonce_d;

    assign batch_complete = (state_q == ST_WAIT) && (&core_done);
    // Bit 32 of the widened sum flags that the last batch of the nonce space just finished.
    assign base_sum       = {1'b0, base_q} + 33'(NUM_CORES);
    assign next_base_d    = (state_q == ST_IDLE) ? NONCE_START : base_sum[31:0];

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_nonce
            assign core_nonce_d[32*gi +: 32] = next_base_d + 32'(gi);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            base_q       <= 32'd0;
            core_work_q  <= '0;
            core_nonce_q <= '0;
            work_ready_q <= 1'b1;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (work_valid) begin
                        core_work_q  <= work_data;
                        base_q       <= next_base_d;
                        core_nonce_q <= core_nonce_d;
                        core_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        work_ready_q <= 1'b0;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // core_done seen here is left over from the previous batch.
                    if (flush) begin
                        busy_q       <= 1'b0;
                        work_ready_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        busy_q       <= 1'b0;
                        work_ready_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else if (&core_done) begin
                        if (|core_found) begin
                            found_q      <= 1'b1;
                            busy_q       <= 1'b0;
                            work_ready_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else if (base_sum[32]) begin
                            exhausted_q  <= 1'b1;
                            busy_q       <= 1'b0;
                            work_ready_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else begin
                            base_q       <= next_base_d;
                            core_nonce_q <= core_nonce_d;
                            core_start_q <= 1'b1;
                            state_q      <= ST_ISSUE;
                        end
                    end
                end
                default: begin
                    busy_q       <= 1'b0;
                    work_ready_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign work_ready = work_ready_q;
    assign core_work  = core_work_q;
    assign core_nonce = core_nonce_q;
    assign core_start = core_start_q;
    assign busy       = busy_q;
    assign found      = found_q;
    assign exhausted  = exhausted_q;

`ifdef SHA_IN_STATS_EN
    logic [47:0] hash_count_q;
    logic [48:0] hash_sum;

    assign hash_sum = {1'b0, hash_count_q} + 49'(NUM_CORES);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            hash_count_q <= 48'd0;
        end else if ((state_q == ST_IDLE) && work_valid) begin
            hash_count_q <= 48'd0;
        end else if (batch_complete && !flush) begin
            hash_count_q <= hash_sum[48] ? {48{1'b1}} : hash_sum[47:0];
        end
    end

    assign hash_count = hash_count_q;
`endif

endmodule

// File: tb/tb_sha_input_manager.sv
// Randomized self-checking bench for sha_input_manager (NUM_CORES=4) against a transaction-level model.
module tb_sha_input_manager;

    localparam int N = 4;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         n_rst;
    logic         work_valid, work_ready, flush, core_start, busy, found, exhausted;
    logic [351:0] work_data, core_work;
    logic [127:0] core_nonce;
    logic [3:0]   core_done, core_found;

    logic         b_work_valid, b_work_ready, b_flush, b_core_start, b_busy, b_found, b_exhausted;
    logic [351:0] b_work_data, b_core_work;
    logic [127:0] b_core_nonce;
    logic [3:0]   b_core_done, b_core_found;
`ifdef SHA_IN_STATS_EN
    logic [47:0]  hash_count, b_hash_count;
`endif

    sha_input_manager #(.NUM_CORES(N), .NONCE_START(32'd0)) dut (
        .clk(clk), .n_rst(n_rst), .work_valid(work_valid), .work_ready(work_ready),
        .work_data(work_data), .flush(flush), .core_work(core_work), .core_nonce(core_nonce),
        .core_start(core_start), .core_done(core_done), .core_found(core_found),
        .busy(busy), .found(found), .exhausted(exhausted)
`ifdef SHA_IN_STATS_EN
        , .hash_count(hash_count)
`endif
    );

    sha_input_manager #(.NUM_CORES(N), .NONCE_START(32'hFFFF_FFFC)) dut_hi (
        .clk(clk), .n_rst(n_rst), .work_valid(b_work_valid), .work_ready(b_work_ready),
        .work_data(b_work_data), .flush(b_flush), .core_work(b_core_work), .core_nonce(b_core_nonce),
        .core_start(b_core_start), .core_done(b_core_done), .core_found(b_core_found),
        .busy(b_busy), .found(b_found), .exhausted(b_exhausted)
`ifdef SHA_IN_STATS_EN
        , .hash_count(b_hash_count)
`endif
    );

    int           checks = 0;
    int           failures = 0;
    longint       exp_base;
    logic [351:0] exp_work;
    longint       exp_hashes;

    task automatic check_eq(input string tag, input logic [351:0] obs, input logic [351:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Core i of a batch starting at base hashes nonce base+i.
    function automatic logic [127:0] batch_nonces(input longint base);
        logic [127:0] v;
        for (int i = 0; i < N; i++) v[32*i +: 32] = 32'(base + i);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string tag);
`ifdef SHA_IN_STATS_EN
        check_eq({tag, ".hashes"}, 352'(hash_count), 352'(exp_hashes));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic chk_idle(input string tag, input logic ef, input logic ee);
        check_eq({tag, ".ready"}, 352'(work_ready), 352'(1'b1));
        check_eq({tag, ".busy"}, 352'(busy), 352'(1'b0));
        check_eq({tag, ".start"}, 352'(core_start), 352'(1'b0));
        check_eq({tag, ".found"}, 352'(found), 352'(ef));
        check_eq({tag, ".exh"}, 352'(exhausted), 352'(ee));
        check_eq({tag, ".work"}, core_work, exp_work);
        check_eq({tag, ".nonce"}, 352'(core_nonce), 352'(batch_nonces(exp_base)));
    endtask

    task automatic chk_issue(input string tag);
        check_eq({tag, ".start"}, 352'(core_start), 352'(1'b1));
        check_eq({tag, ".busy"}, 352'(busy), 352'(1'b1));
        check_eq({tag, ".ready"}, 352'(work_ready), 352'(1'b0));
        check_eq({tag, ".work"}, core_work, exp_work);
        check_eq({tag, ".nonce"}, 352'(core_nonce), 352'(batch_nonces(exp_base)));
        check_eq({tag, ".pulses"}, 352'({found, exhausted}), 352'(2'b00));
    endtask

    task automatic chk_reset(input string tag);
        check_eq({tag, ".ready"}, 352'(work_ready), 352'(1'b1));
        check_eq({tag, ".outs"}, 352'({core_start, busy, found, exhausted}), 352'(4'b0000));
        check_eq({tag, ".work"}, core_work, 352'(0));
        check_eq({tag, ".nonce"}, 352'(core_nonce), 352'(0));
        exp_hashes = 0;
        chk_stats(tag);
    endtask

    task automatic accept(input logic with_flush);
        for (int i = 0; i < 11; i++) work_data[32*i +: 32] = $urandom;
        work_valid = 1'b1;
        flush      = with_flush;
        core_done  = 4'h0;
        core_found = 4'h0;
        step();
        work_valid = 1'b0;
        flush      = 1'b0;
        exp_work   = work_data;
        exp_base   = 0;
        exp_hashes = 0;
        chk_issue("accept");
        chk_stats("accept");
    endtask

    // Leave the ISSUE cycle while presenting stale done/found levels.
    task automatic leave_issue();
        core_done  = 4'($urandom);
        core_found = 4'($urandom);
        step();
        check_eq("wait.start", 352'(core_start), 352'(1'b0));
        check_eq("wait.busy", 352'(busy), 352'(1'b1));
    endtask

    task automatic hold_partial(input int cycles, input logic fixed);
        for (int k = 0; k < cycles; k++) begin
            core_done  = fixed ? 4'b0111 : 4'($urandom_range(0, 14));
            core_found = 4'($urandom);
            work_valid = $urandom_range(0, 1) == 1;
            for (int i = 0; i < 11; i++) work_data[32*i +: 32] = $urandom;
            step();
            check_eq("partial.state", 352'({busy, work_ready, core_start, found, exhausted}), 352'(5'b10000));
            check_eq("partial.work", core_work, exp_work);
        end
        work_valid = 1'b0;
    endtask

    task automatic complete(input logic [3:0] fmask);
        core_done  = 4'hF;
        core_found = fmask;
        step();
        exp_hashes += N;
        chk_stats("complete");
        if (fmask != 4'h0) begin
            chk_idle("found", 1'b1, 1'b0);
            core_done  = 4'h0;
            core_found = 4'h0;
            step();
            chk_idle("post_found", 1'b0, 1'b0);
        end else begin
            exp_base += N;
            chk_issue("next_batch");
        end
    endtask

    task automatic flush_in_wait();
        core_done  = 4'hF;
        core_found = 4'h1;
        flush      = 1'b1;
        step();
        flush      = 1'b0;
        core_done  = 4'h0;
        core_found = 4'h0;
        chk_idle("flush", 1'b0, 1'b0);
        chk_stats("flush");
    endtask

    initial begin
        n_rst = 1'b0; work_valid = 1'b0; flush = 1'b0; work_data = '0;
        core_done = 4'h0; core_found = 4'h0;
        b_work_valid = 1'b0; b_flush = 1'b0; b_work_data = '0; b_core_done = 4'h0; b_core_found = 4'h0;
        exp_base = 0; exp_work = '0; exp_hashes = 0;
        step(); step();
        chk_reset("reset");
        n_rst = 1'b1;
        step();

        // Partial completion holds WAIT; second batch finds.
        accept(1'b0);
        leave_issue();
        hold_partial(10, 1'b1);
        complete(4'h0);
        leave_issue();
        complete(4'b0100);

        // Flush has priority over a completing batch with a find.
        accept(1'b0);
        leave_issue();
        flush_in_wait();

        // Flush in the ISSUE cycle.
        accept(1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_idle("flush_issue", 1'b0, 1'b0);

        // Randomized work units.
        for (int w = 0; w < 12; w++) begin
            int nb;
            accept(w % 3 == 0);
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                leave_issue();
                hold_partial($urandom_range(0, 4), 1'b0);
                if (b == nb - 1) begin
                    if (w % 4 == 1) flush_in_wait();
                    else complete(4'($urandom_range(1, 15)));
                end else begin
                    complete(4'h0);
                end
            end
        end

        // Reset mid-WAIT with a completing, finding batch on the inputs.
        accept(1'b0);
        leave_issue();
        n_rst = 1'b0; core_done = 4'hF; core_found = 4'h1;
        step();
        chk_reset("reset_mid");
        n_rst = 1'b1; core_done = 4'h0; core_found = 4'h0;
        step();

        // Top-of-space start: one batch, then exhaustion.
        for (int i = 0; i < 11; i++) b_work_data[32*i +: 32] = $urandom;
        b_work_valid = 1'b1;
        step();
        b_work_valid = 1'b0;
        exp_base = 64'hFFFF_FFFC;
        check_eq("hi.start", 352'(b_core_start), 352'(1'b1));
        check_eq("hi.nonce", 352'(b_core_nonce), 352'(batch_nonces(exp_base)));
        check_eq("hi.work", b_core_work, b_work_data);
        b_core_done = 4'hF;
        step();
        check_eq("hi.wait", 352'({b_busy, b_core_start, b_exhausted}), 352'(3'b100));
        step();
        check_eq("hi.exh", 352'(b_exhausted), 352'((exp_base + N) > 64'hFFFF_FFFF));
        check_eq("hi.idle", 352'({b_work_ready, b_busy, b_core_start, b_found}), 352'(4'b1000));
        step();
        check_eq("hi.after", 352'({b_core_start, b_exhausted, b_busy}), 352'(3'b000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
